// File: rtl/disp_pkg.sv
// Shared display-path types: packed RGB pixel and the pixel field layout of a 64-bit fetch word.
package disp_pkg;

   localparam int PIX_W    = 24;
   localparam int PIX0_LSB = 0;
   localparam int PIX1_LSB = 32;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   // Bits [31:24] and [63:56] of a fetch word are padding and never selected here.
   function automatic rgb_t word_pixel(input logic [63:0] word, input logic sel);
      rgb_t pix;
      pix = sel ? rgb_t'(word[PIX1_LSB +: PIX_W]) : rgb_t'(word[PIX0_LSB +: PIX_W]);
      return pix;
   endfunction

endpackage

// File: rtl/disp_pixbuf_mem.sv
// Pixel word storage for disp_pixbuf: simple dual-port RAM, synchronous write, combinational read.
module disp_pixbuf_mem #(
   parameter int DEPTH = 1024,
   parameter int WIDTH = 48,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/disp_pixbuf.sv
// Pixel buffer between frame fetch and display timing: stores packed RGB words, unpacks one pixel per request.
// Optional build macro DISP_PIXBUF_UFILL_EN: drive FILL_RGB instead of holding RGB on underflow.
module disp_pixbuf
   import disp_pkg::*;
#(
   parameter int          DEPTH        = 1024,
   parameter int          PIX_PER_WORD = 2,
   parameter int          WREADY_SPACE = 256,
   parameter logic [23:0] FILL_RGB     = 24'h000000
) (
   input  logic                     ACLK,
   input  logic                     ARSTN,
   input  logic                     DISPON,
   input  logic                     FIFORST,
   input  logic [63:0]              FIFOIN,
   input  logic                     FIFOWR,
   input  logic                     DSP_preDE,
   output logic                     BUF_WREADY,
   output logic                     BUF_OVER,
   output logic                     BUF_UNDER,
   output logic [$clog2(DEPTH):0]   BUF_LEVEL,
   output logic [7:0]               DSP_R,
   output logic [7:0]               DSP_G,
   output logic [7:0]               DSP_B,
   output logic                     DSP_DE
);

   localparam int          AW           = $clog2(DEPTH);
   localparam int          WIDTH        = PIX_W * PIX_PER_WORD;
   localparam logic [AW:0] FULL_CNT     = (AW+1)'(DEPTH);
   localparam logic [AW:0] WREADY_LIMIT = (AW+1)'(DEPTH - WREADY_SPACE);
   localparam logic [AW:0] CNT_ONE      = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE    = AW'(1);
   localparam logic        LAST_IDX     = 1'(PIX_PER_WORD - 1);

   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic [AW:0]      count_next;
   logic             wready;
   logic             wready_next;
   logic             over;
   logic             under;
   logic             head_valid;
   logic [WIDTH-1:0] head_word;
   logic             head_idx;
   logic             head_last;
   logic             consume;
   logic             underflow;
   logic             wr_en;
   logic             rd_en;
   logic [WIDTH-1:0] store_word;
   logic [WIDTH-1:0] rd_data;
   rgb_t             head_pix;
   rgb_t             rgb;
   logic             de;
   logic             unused_bits;

   assign unused_bits = ^{FIFOIN[63:56], FIFOIN[55:32], FIFOIN[31:24], FILL_RGB};

   generate
      if (PIX_PER_WORD == 2) begin : g_two
         assign store_word = {word_pixel(FIFOIN, 1'b1), word_pixel(FIFOIN, 1'b0)};
         assign head_pix   = head_idx ? rgb_t'(head_word[2*PIX_W-1:PIX_W])
                                      : rgb_t'(head_word[PIX_W-1:0]);
      end else begin : g_one
         assign store_word = word_pixel(FIFOIN, 1'b0);
         assign head_pix   = rgb_t'(head_word[PIX_W-1:0]);
      end
   endgenerate

   // Full is judged on the pre-edge count, so a same-cycle head refill never makes room.
   assign wr_en     = FIFOWR && (count != FULL_CNT) && !FIFORST;
   assign head_last = (head_idx == LAST_IDX);
   assign consume   = DSP_preDE && head_valid;
   assign underflow = DSP_preDE && !head_valid;
   assign rd_en     = (count != '0) && (!head_valid || (consume && head_last)) && !FIFORST;

   always_comb begin
      count_next = count;
      if (wr_en && !rd_en) begin
         count_next = count + CNT_ONE;
      end else if (!wr_en && rd_en) begin
         count_next = count - CNT_ONE;
      end
      wready_next = (count_next <= WREADY_LIMIT);
   end

   disp_pixbuf_mem #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH),
      .AW    (AW)
   ) u_mem (
      .clk     (ACLK),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr),
      .wr_data (store_word),
      .rd_addr (rd_ptr),
      .rd_data (rd_data)
   );

   always_ff @(posedge ACLK or negedge ARSTN) begin
      if (!ARSTN) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         wready     <= 1'b1;
         over       <= 1'b0;
         under      <= 1'b0;
         head_valid <= 1'b0;
         head_word  <= '0;
         head_idx   <= 1'b0;
         rgb        <= '0;
      end else if (FIFORST) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         wready     <= 1'b1;
         over       <= 1'b0;
         under      <= 1'b0;
         head_valid <= 1'b0;
         head_idx   <= 1'b0;
         rgb        <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         count  <= count_next;
         wready <= wready_next;

         // A refill wins over index advance: it covers both an empty head and a just-finished word.
         if (rd_en) begin
            head_valid <= 1'b1;
            head_word  <= rd_data;
            head_idx   <= 1'b0;
         end else if (consume) begin
            if (head_last) begin
               head_valid <= 1'b0;
            end else begin
               head_idx <= 1'b1;
            end
         end

         if (FIFOWR && (count == FULL_CNT)) begin
            over <= 1'b1;
         end
         if (underflow) begin
            under <= 1'b1;
         end

         // Requests still consume pixels with the display off, keeping the buffer in step with scan timing.
         if (!DISPON) begin
            rgb <= '0;
         end else if (consume) begin
            rgb <= head_pix;
`ifdef DISP_PIXBUF_UFILL_EN
         end else if (underflow) begin
            rgb <= FILL_RGB;
`endif
         end
      end
   end

   always_ff @(posedge ACLK or negedge ARSTN) begin
      if (!ARSTN) begin
         de <= 1'b0;
      end else begin
         de <= DSP_preDE;
      end
   end

   assign BUF_WREADY = wready;
   assign BUF_OVER   = over;
   assign BUF_UNDER  = under;
   assign BUF_LEVEL  = count;
   assign DSP_R      = rgb.r;
   assign DSP_G      = rgb.g;
   assign DSP_B      = rgb.b;
   assign DSP_DE     = de;

endmodule

// File: tb/tb_disp_pixbuf.sv
// Scoreboard bench for disp_pixbuf: a 1024x2 instance and a 16x1 instance for pointer wrap.
module tb_disp_pixbuf;

   logic        ACLK = 1'b0;
   logic        ARSTN;
   logic        DISPON;
   logic        FIFORST;
   logic [63:0] FIFOIN;
   logic        FIFOWR;
   logic        DSP_preDE;
   logic        BUF_WREADY;
   logic        BUF_OVER;
   logic        BUF_UNDER;
   logic [10:0] BUF_LEVEL;
   logic [7:0]  DSP_R;
   logic [7:0]  DSP_G;
   logic [7:0]  DSP_B;
   logic        DSP_DE;

   logic [63:0] s_fifoin;
   logic        s_fifowr;
   logic        s_pre;
   logic        s_wready;
   logic        s_over;
   logic        s_under;
   logic [4:0]  s_level;
   logic [7:0]  s_r;
   logic [7:0]  s_g;
   logic [7:0]  s_b;
   logic        s_de;

   int          checks = 0;
   int          errors = 0;
   logic [23:0] exp_q[$];
   logic [23:0] exp_s[$];

   always #5 ACLK = ~ACLK;

   disp_pixbuf dut (
      .ACLK       (ACLK),
      .ARSTN      (ARSTN),
      .DISPON     (DISPON),
      .FIFORST    (FIFORST),
      .FIFOIN     (FIFOIN),
      .FIFOWR     (FIFOWR),
      .DSP_preDE  (DSP_preDE),
      .BUF_WREADY (BUF_WREADY),
      .BUF_OVER   (BUF_OVER),
      .BUF_UNDER  (BUF_UNDER),
      .BUF_LEVEL  (BUF_LEVEL),
      .DSP_R      (DSP_R),
      .DSP_G      (DSP_G),
      .DSP_B      (DSP_B),
      .DSP_DE     (DSP_DE)
   );

   disp_pixbuf #(
      .DEPTH        (16),
      .PIX_PER_WORD (1),
      .WREADY_SPACE (4)
   ) dut_small (
      .ACLK       (ACLK),
      .ARSTN      (ARSTN),
      .DISPON     (1'b1),
      .FIFORST    (1'b0),
      .FIFOIN     (s_fifoin),
      .FIFOWR     (s_fifowr),
      .DSP_preDE  (s_pre),
      .BUF_WREADY (s_wready),
      .BUF_OVER   (s_over),
      .BUF_UNDER  (s_under),
      .BUF_LEVEL  (s_level),
      .DSP_R      (s_r),
      .DSP_G      (s_g),
      .DSP_B      (s_b),
      .DSP_DE     (s_de)
   );

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic apply_stimulus(input logic wr, input logic [63:0] din, input logic pre, input logic rst);
      FIFOWR    = wr;
      FIFOIN    = din;
      DSP_preDE = pre;
      FIFORST   = rst;
      @(posedge ACLK);
      #1;
      FIFOWR    = 1'b0;
      DSP_preDE = 1'b0;
      FIFORST   = 1'b0;
   endtask

   task automatic apply_small(input logic wr, input logic [63:0] din, input logic pre);
      s_fifowr = wr;
      s_fifoin = din;
      s_pre    = pre;
      @(posedge ACLK);
      #1;
      s_fifowr = 1'b0;
      s_pre    = 1'b0;
   endtask

   function automatic logic [63:0] make_word(input int i);
      logic [15:0] v;
      v = i[15:0];
      return {8'hA5, 8'h20, v, 8'h5A, 8'h10, v};
   endfunction

   function automatic logic [63:0] small_word(input int i);
      logic [7:0] v;
      v = i[7:0];
      return {8'hEE, 24'h987654, 8'h66, 8'h3C, 8'hC3, v};
   endfunction

   always @(negedge ACLK) begin
      if (ARSTN === 1'b1 && DSP_DE === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL main_pixel actual=%h required=no DSP_DE", {DSP_R, DSP_G, DSP_B});
         end else begin
            logic [23:0] e;
            e = exp_q.pop_front();
            if ({DSP_R, DSP_G, DSP_B} !== e) begin
               errors++;
               $display("[TB] FAIL main_pixel actual=%h required=%h", {DSP_R, DSP_G, DSP_B}, e);
            end
         end
      end
   end

   always @(negedge ACLK) begin
      if (ARSTN === 1'b1 && s_de === 1'b1) begin
         checks++;
         if (exp_s.size() == 0) begin
            errors++;
            $display("[TB] FAIL small_pixel actual=%h required=no DSP_DE", {s_r, s_g, s_b});
         end else begin
            logic [23:0] e;
            e = exp_s.pop_front();
            if ({s_r, s_g, s_b} !== e) begin
               errors++;
               $display("[TB] FAIL small_pixel actual=%h required=%h", {s_r, s_g, s_b}, e);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      ARSTN     = 1'b0;
      DISPON    = 1'b1;
      FIFORST   = 1'b0;
      FIFOWR    = 1'b0;
      FIFOIN    = '0;
      DSP_preDE = 1'b0;
      s_fifowr  = 1'b0;
      s_fifoin  = '0;
      s_pre     = 1'b0;
      repeat (2) @(posedge ACLK);
      #1;
      check_output("reset_level",  BUF_LEVEL,  0);
      check_output("reset_wready", BUF_WREADY, 1);
      check_output("reset_over",   BUF_OVER,   0);
      check_output("reset_under",  BUF_UNDER,  0);
      check_output("reset_rgb",    {DSP_R, DSP_G, DSP_B}, 0);
      check_output("reset_de",     DSP_DE,     0);
      ARSTN = 1'b1;
      @(posedge ACLK);
      #1;

      // Two words then four requests.
      apply_stimulus(1'b1, 64'h00AABBCC_00112233, 1'b0, 1'b0);
      apply_stimulus(1'b1, 64'h00DDEEFF_00445566, 1'b0, 1'b0);
      check_output("t1_level_after_head_load", BUF_LEVEL, 1);
      exp_q.push_back(24'h112233);
      apply_stimulus(1'b0, '0, 1'b1, 1'b0);
      exp_q.push_back(24'hAABBCC);
      apply_stimulus(1'b0, '0, 1'b1, 1'b0);
      exp_q.push_back(24'h445566);
      apply_stimulus(1'b0, '0, 1'b1, 1'b0);
      exp_q.push_back(24'hDDEEFF);
      apply_stimulus(1'b0, '0, 1'b1, 1'b0);
      apply_stimulus(1'b0, '0, 1'b0, 1'b0);
      check_output("t1_level_empty", BUF_LEVEL, 0);
      check_output("t1_under_clear", BUF_UNDER, 0);

      // Underflow on an empty buffer.
`ifdef DISP_PIXBUF_UFILL_EN
      exp_q.push_back(24'h000000);
`else
      exp_q.push_back(24'hDDEEFF);
`endif
      apply_stimulus(1'b0, '0, 1'b1, 1'b0);
      check_output("under_set", BUF_UNDER, 1);

      apply_stimulus(1'b0, '0, 1'b0, 1'b1);
      check_output("clr_under", BUF_UNDER, 0);
      check_output("clr_rgb",   {DSP_R, DSP_G, DSP_B}, 0);
      check_output("clr_level", BUF_LEVEL, 0);

      // Fill to capacity (1024 in storage plus the head), then one dropped write.
      for (int i = 0; i < 1026; i++) begin
         apply_stimulus(1'b1, make_word(i), 1'b0, 1'b0);
         if (i == 768) begin
            check_output("lvl768_level",  BUF_LEVEL,  768);
            check_output("lvl768_wready", BUF_WREADY, 1);
         end
         if (i == 769) begin
            check_output("lvl769_level",  BUF_LEVEL,  769);
            check_output("lvl769_wready", BUF_WREADY, 0);
         end
         if (i == 1024) begin
            check_output("full_level", BUF_LEVEL, 1024);
            check_output("full_over",  BUF_OVER,  0);
         end
         if (i == 1025) begin
            check_output("overflow_level", BUF_LEVEL, 1024);
            check_output("overflow_over",  BUF_OVER,  1);
         end
      end

      // Drain everything; the first four requests run with the display off.
      for (int k = 0; k < 2050; k++) begin
         logic [15:0] v;
         logic [23:0] px;
         v  = 16'(k / 2);
         px = (k % 2 == 1) ? {8'h20, v} : {8'h10, v};
         DISPON = (k >= 4);
         exp_q.push_back(DISPON ? px : 24'h000000);
         apply_stimulus(1'b0, '0, 1'b1, 1'b0);
      end
      DISPON = 1'b1;
      apply_stimulus(1'b0, '0, 1'b0, 1'b0);
      check_output("drain_level",  BUF_LEVEL,  0);
      check_output("drain_under",  BUF_UNDER,  0);
      check_output("drain_wready", BUF_WREADY, 1);

      // Mid-stream clear with a simultaneous write and request.
      apply_stimulus(1'b1, 64'h11A1A2A3_22B1B2B3, 1'b0, 1'b0);
      apply_stimulus(1'b1, 64'h33C1C2C3_44D1D2D3, 1'b0, 1'b0);
      apply_stimulus(1'b1, 64'h55E1E2E3_66F1F2F3, 1'b0, 1'b0);
      exp_q.push_back(24'hB1B2B3);
      apply_stimulus(1'b0, '0, 1'b1, 1'b0);
      exp_q.push_back(24'hA1A2A3);
      apply_stimulus(1'b0, '0, 1'b1, 1'b0);
      exp_q.push_back(24'h000000);
      apply_stimulus(1'b1, 64'h77123456_88654321, 1'b1, 1'b1);
      repeat (3) apply_stimulus(1'b0, '0, 1'b0, 1'b0);
      check_output("rst_level",  BUF_LEVEL,  0);
      check_output("rst_over",   BUF_OVER,   0);
      check_output("rst_under",  BUF_UNDER,  0);
      check_output("rst_rgb",    {DSP_R, DSP_G, DSP_B}, 0);
      check_output("rst_wready", BUF_WREADY, 1);
      exp_q.push_back(24'h000000);
      apply_stimulus(1'b0, '0, 1'b1, 1'b0);
      check_output("rst_word_discarded_under", BUF_UNDER, 1);

      // Small instance: 60 single-pixel words through a 16-deep store.
      for (int i = 0; i < 10; i++) begin
         apply_small(1'b1, small_word(i), 1'b0);
      end
      for (int k = 0; k < 50; k++) begin
         logic [7:0] v;
         v = k[7:0];
         exp_s.push_back({8'h3C, 8'hC3, v});
         apply_small(1'b1, small_word(10 + k), 1'b1);
         if (k == 25) begin
            check_output("small_level_steady",  s_level,  9);
            check_output("small_wready_steady", s_wready, 1);
         end
      end
      for (int k = 50; k < 60; k++) begin
         logic [7:0] v;
         v = k[7:0];
         exp_s.push_back({8'h3C, 8'hC3, v});
         apply_small(1'b0, '0, 1'b1);
      end
      apply_small(1'b0, '0, 1'b0);
      check_output("small_level_end", s_level, 0);
      check_output("small_under",     s_under, 0);
      check_output("small_over",      s_over,  0);

      repeat (3) apply_stimulus(1'b0, '0, 1'b0, 1'b0);
      check_output("main_sb_drained",  exp_q.size(), 0);
      check_output("small_sb_drained", exp_s.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
